// File: rtl/bin_serializer_pkg.sv
// Shared definitions for the ASCII byte serializer: FSM state encoding,
// line levels and the frame-length helper.
package bin_serializer_pkg;

   // Serializer FSM states
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   // Line levels for idle/stop and for the start bit
   localparam logic IDLE_LEVEL  = 1'b1;
   localparam logic START_LEVEL = 1'b0;

   // Clocks occupied by one complete frame:
   // start + 8 data + optional parity + stop bits, each clks long.
   function automatic int unsigned frame_cycles(input int unsigned clks,
                                                input int unsigned par,
                                                input int unsigned stops);
      return (32'd9 + par + stops) * clks;
   endfunction

endpackage

// File: rtl/bin_serializer_bit_timer.sv
// Per-bit cycle counter for the serializer. Counts 0..CLKS_PER_BIT-1 and
// wraps at every bit boundary; held at zero while restart is asserted.
module bit_timer #(
   parameter int unsigned CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_restart,
   output logic o_bit_first,
   output logic o_bit_last,
   output logic o_next_last
);

   localparam int unsigned    CW   = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CW-1:0]  LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_next;

   // With CLKS_PER_BIT = 1 the counter stays at zero and every cycle is
   // both the first and the last cycle of a bit.
   assign o_bit_first = (r_cnt == '0);
   assign o_bit_last  = (r_cnt == LAST);

   // Next count: wrap at the bit boundary, park at zero on restart
   always_comb begin
      w_cnt_next = r_cnt + 1'b1;
      if (i_restart || o_bit_last) begin
         w_cnt_next = '0;
      end
   end

   // Lets the parent register pulses that must land on a bit's last cycle
   assign o_next_last = (w_cnt_next == LAST);

   // Cycle counter register with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= w_cnt_next;
      end
   end

endmodule

// File: rtl/bin_serializer.sv
// Parallel-to-serial framing stage: accepts one ASCII byte per valid/ready
// handshake and sends start, 8 data bits MSB-first, optional even parity
// and 1 or 2 stop bits, each held CLKS_PER_BIT clocks.
module bin_serializer
   import bin_serializer_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 4,
   parameter int unsigned PARITY_EN    = 1,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       in_ready,
   output logic       tx_bit,
   output logic       tx_busy,
   output logic       bit_strobe,
   output logic       frame_done
);

   localparam logic LAST_STOP = (STOP_BITS == 2) ? 1'b1 : 1'b0;

   state_t     r_state;
   logic [2:0] r_bit_idx;
   logic       r_stop_idx;
   logic [7:0] r_shift;
   logic       r_parity;
   logic       r_ready_en;
   logic       r_tx_bit;
   logic       r_tx_busy;
   logic       r_bit_strobe;
   logic       r_frame_done;

   state_t     w_state_next;
   logic [2:0] w_bit_idx_next;
   logic       w_stop_idx_next;
   logic [7:0] w_shift_next;
   logic       w_parity_next;
   logic       w_tx_next;
   logic       w_strobe_next;
   logic       w_done_next;

   logic       w_bit_first;
   logic       w_bit_last;
   logic       w_next_last;
   logic       w_final_cycle;
   logic       w_accept;

   bit_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_bit_timer (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_restart   (r_state == IDLE),
      .o_bit_first (w_bit_first),
      .o_bit_last  (w_bit_last),
      .o_next_last (w_next_last)
   );

   // Last cycle of the last stop bit: the slot where a follow-on byte is taken
   assign w_final_cycle = (r_state == STOP) && (r_stop_idx == LAST_STOP) && w_bit_last;

   // r_ready_en keeps ready low until the first cycle after reset is released
   assign in_ready = rst_n && r_ready_en && ((r_state == IDLE) || w_final_cycle);
   assign w_accept = in_valid && in_ready;

   // Next-state, next-line-level and strobe decode for the upcoming cycle.
   // Outputs are registered from these values so each flop already holds
   // the level of the bit that is on the line in that cycle.
   always_comb begin
      w_state_next    = r_state;
      w_bit_idx_next  = r_bit_idx;
      w_stop_idx_next = r_stop_idx;
      w_shift_next    = r_shift;
      w_parity_next   = r_parity;
      w_tx_next       = r_tx_bit;
      w_strobe_next   = 1'b0;

      if (w_accept) begin
         w_state_next  = START;
         w_shift_next  = in_data;
         w_parity_next = ^in_data;
         w_tx_next     = START_LEVEL;
         w_strobe_next = 1'b1;
      end else begin
         case (r_state)
            IDLE: begin
               w_tx_next = IDLE_LEVEL;
            end

            START: begin
               if (w_bit_last) begin
                  w_state_next   = DATA;
                  w_bit_idx_next = 3'd0;
                  w_tx_next      = r_shift[7];
                  w_strobe_next  = 1'b1;
               end
            end

            DATA: begin
               // The bit on the line is dropped from the shifter on its
               // first cycle, so the next bit is always the post-shift MSB,
               // including when first and last cycle coincide.
               if (w_bit_first) begin
                  w_shift_next = {r_shift[6:0], 1'b0};
               end
               if (w_bit_last) begin
                  w_strobe_next = 1'b1;
                  if (r_bit_idx == 3'd7) begin
                     if (PARITY_EN != 0) begin
                        w_state_next = PARITY;
                        w_tx_next    = r_parity;
                     end else begin
                        w_state_next    = STOP;
                        w_stop_idx_next = 1'b0;
                        w_tx_next       = IDLE_LEVEL;
                     end
                  end else begin
                     w_bit_idx_next = r_bit_idx + 3'd1;
                     w_tx_next      = w_shift_next[7];
                  end
               end
            end

            PARITY: begin
               if (w_bit_last) begin
                  w_state_next    = STOP;
                  w_stop_idx_next = 1'b0;
                  w_tx_next       = IDLE_LEVEL;
                  w_strobe_next   = 1'b1;
               end
            end

            STOP: begin
               if (w_bit_last) begin
                  w_tx_next = IDLE_LEVEL;
                  if (r_stop_idx == LAST_STOP) begin
                     w_state_next = IDLE;
                  end else begin
                     w_stop_idx_next = 1'b1;
                     w_strobe_next   = 1'b1;
                  end
               end
            end

            default: begin
               w_state_next = IDLE;
               w_tx_next    = IDLE_LEVEL;
            end
         endcase
      end

      // frame_done lands on the last cycle of the last stop bit
      w_done_next = (w_state_next == STOP) && (w_stop_idx_next == LAST_STOP) && w_next_last;
   end

   // State, datapath and registered outputs; reset abandons any frame in flight
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_bit_idx    <= '0;
         r_stop_idx   <= 1'b0;
         r_shift      <= '0;
         r_parity     <= 1'b0;
         r_ready_en   <= 1'b0;
         r_tx_bit     <= IDLE_LEVEL;
         r_tx_busy    <= 1'b0;
         r_bit_strobe <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_bit_idx    <= w_bit_idx_next;
         r_stop_idx   <= w_stop_idx_next;
         r_shift      <= w_shift_next;
         r_parity     <= w_parity_next;
         r_ready_en   <= 1'b1;
         r_tx_bit     <= w_tx_next;
         r_tx_busy    <= (w_state_next != IDLE);
         r_bit_strobe <= w_strobe_next;
         r_frame_done <= w_done_next;
      end
   end

   assign tx_bit     = r_tx_bit;
   assign tx_busy    = r_tx_busy;
   assign bit_strobe = r_bit_strobe;
   assign frame_done = r_frame_done;

endmodule

// File: tb/tb_bin_serializer.sv
// Bench for bin_serializer: three configurations driven side by side, each
// compared every cycle against a frame-level reference model, plus directed
// measurements of latency, bit order, parity and reset behaviour.
module tb_bin_serializer;
   import bin_serializer_pkg::*;

   localparam int unsigned NI = 3;
   localparam int unsigned CPB0 = 4, PAR0 = 1, STP0 = 1;
   localparam int unsigned CPB1 = 1, PAR1 = 0, STP1 = 2;
   localparam int unsigned CPB2 = 4, PAR2 = 1, STP2 = 2;
   localparam int unsigned CFG_CPB [NI] = '{CPB0, CPB1, CPB2};
   localparam int unsigned CFG_PAR [NI] = '{PAR0, PAR1, PAR2};
   localparam int unsigned CFG_STP [NI] = '{STP0, STP1, STP2};

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [NI-1:0] in_valid = '0;
   logic [7:0]    in_data [NI];
   logic [NI-1:0] in_ready, tx_bit, tx_busy, bit_strobe, frame_done;

   int n_pass  = 0;
   int n_total = 0;
   int cyc     = 0;
   bit mon_en  = 1'b0;

   always #5 clk = ~clk;

   bin_serializer #(.CLKS_PER_BIT(CPB0), .PARITY_EN(PAR0), .STOP_BITS(STP0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_data(in_data[0]),
      .in_ready(in_ready[0]), .tx_bit(tx_bit[0]), .tx_busy(tx_busy[0]),
      .bit_strobe(bit_strobe[0]), .frame_done(frame_done[0]));

   bin_serializer #(.CLKS_PER_BIT(CPB1), .PARITY_EN(PAR1), .STOP_BITS(STP1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_data(in_data[1]),
      .in_ready(in_ready[1]), .tx_bit(tx_bit[1]), .tx_busy(tx_busy[1]),
      .bit_strobe(bit_strobe[1]), .frame_done(frame_done[1]));

   bin_serializer #(.CLKS_PER_BIT(CPB2), .PARITY_EN(PAR2), .STOP_BITS(STP2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_data(in_data[2]),
      .in_ready(in_ready[2]), .tx_bit(tx_bit[2]), .tx_busy(tx_busy[2]),
      .bit_strobe(bit_strobe[2]), .frame_done(frame_done[2]));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic tx;
      logic busy;
      logic strobe;
      logic done;
   } exp_t;

   exp_t exp_q [NI][$];
   bit   ready_en [NI];

   function automatic bit model_ready(input int unsigned i);
      return rst_n && ready_en[i] && (exp_q[i].size() <= 1);
   endfunction

   // Expand one byte into the per-cycle line picture of its frame
   task automatic push_frame(input int unsigned i, input logic [7:0] b);
      logic lvl [$];
      exp_t e;
      lvl.push_back(1'b0);
      for (int k = 7; k >= 0; k--) lvl.push_back(b[k]);
      if (CFG_PAR[i] != 0) lvl.push_back(($countones(b) % 2) == 1);
      for (int s = 0; s < int'(CFG_STP[i]); s++) lvl.push_back(1'b1);
      for (int k = 0; k < lvl.size(); k++) begin
         for (int j = 0; j < int'(CFG_CPB[i]); j++) begin
            e.tx     = lvl[k];
            e.busy   = 1'b1;
            e.strobe = (j == 0);
            e.done   = (k == lvl.size() - 1) && (j == int'(CFG_CPB[i]) - 1);
            exp_q[i].push_back(e);
         end
      end
   endtask

   always @(posedge clk) begin
      bit acc;
      cyc++;
      for (int i = 0; i < int'(NI); i++) begin
         if (!rst_n) begin
            exp_q[i].delete();
            ready_en[i] = 1'b0;
         end else begin
            acc = in_valid[i] && model_ready(i);
            if (exp_q[i].size() > 0) void'(exp_q[i].pop_front());
            if (acc) push_frame(i, in_data[i]);
            ready_en[i] = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         for (int i = 0; i < int'(NI); i++) begin
            if (exp_q[i].size() > 0) e = exp_q[i][0];
            else                     e = '{tx: 1'b1, busy: 1'b0, strobe: 1'b0, done: 1'b0};
            chk($sformatf("cyc%0d.u%0d.rdy_tx_busy_stb_done", cyc, i),
                {in_ready[i], tx_bit[i], tx_busy[i], bit_strobe[i], frame_done[i]},
                {model_ready(i), e});
         end
      end
   end

   // ---------------- directed helpers ----------------
   task automatic wait_accept(input int unsigned i, input string tag);
      bit got;
      got = 1'b0;
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         if (in_ready[i]) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) chk({tag, ".accept_timeout"}, 0, 1);
      @(posedge clk);
      #1;
   endtask

   // Send one byte and measure the frame from the DUT's own outputs
   task automatic run_frame(input int unsigned i, input logic [7:0] b, input string tag,
                            output int lat, output int nstrobe, output int nstop_hi,
                            output logic [15:0] bits);
      in_valid[i] = 1'b1;
      in_data[i]  = b;
      wait_accept(i, tag);
      in_valid[i] = 1'b0;
      lat = -1; nstrobe = 0; nstop_hi = 0; bits = '0;
      for (int n = 1; n <= 400; n++) begin
         @(negedge clk);
         if (bit_strobe[i]) begin
            nstrobe++;
            bits = {bits[14:0], tx_bit[i]};
         end
         if (nstrobe > 9 + int'(CFG_PAR[i]) && tx_bit[i]) nstop_hi++;
         if (frame_done[i]) begin
            lat = n;
            break;
         end
      end
      if (lat < 0) chk({tag, ".done_timeout"}, 0, 1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int lat, nstb, nstop, done1, start2, rdy_hi, busy_lo, n;
      logic [15:0] bits;
      bit seen;

      for (int i = 0; i < int'(NI); i++) in_data[i] = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      mon_en = 1'b1;
      @(negedge clk);
      chk("reset.outputs", {in_ready[0], tx_bit[0], tx_busy[0], bit_strobe[0], frame_done[0]}, 5'b01000);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset.ready_before_sample", in_ready[0], 0);
      @(negedge clk);
      chk("reset.ready_after_release", in_ready[0], 1);
      @(posedge clk); #1;

      // 'A' with default configuration
      run_frame(0, 8'h41, "A", lat, nstb, nstop, bits);
      chk("A.latency", lat, 44);
      chk("A.latency_fn", lat, frame_cycles(CPB0, PAR0, STP0));
      chk("A.strobes", nstb, 11);
      chk("A.bits", bits[10:0], 11'b00100000101);
      chk("A.stop_hi", nstop, 4);

      // 'z': five ones, parity must bring the count to six
      run_frame(0, 8'h7A, "z", lat, nstb, nstop, bits);
      chk("z.parity", bits[1], 1);
      chk("z.ones", $countones(bits[9:1]), 6);

      // "Hi" back to back with in_valid held high
      in_valid[0] = 1'b1;
      in_data[0]  = 8'h48;
      wait_accept(0, "Hi");
      in_data[0] = 8'h69;
      done1 = -1; start2 = -1; rdy_hi = 0; busy_lo = 0; seen = 1'b0;
      for (n = 1; n <= 200; n++) begin
         @(negedge clk);
         if (done1 < 0 && in_ready[0]) rdy_hi++;
         if (!tx_busy[0]) busy_lo++;
         if (done1 >= 0 && start2 < 0 && bit_strobe[0]) begin
            start2 = n;
            @(posedge clk); #1;
            in_valid[0] = 1'b0;
            n++;
            @(negedge clk);
            if (!tx_busy[0]) busy_lo++;
         end
         if (frame_done[0]) begin
            if (done1 < 0) begin
               done1 = n;
            end else begin
               seen = 1'b1;
               break;
            end
         end
      end
      in_valid[0] = 1'b0;
      chk("Hi.first_done", done1, 44);
      chk("Hi.second_start", start2, 45);
      chk("Hi.ready_cycles", rdy_hi, 1);
      chk("Hi.busy_gap", busy_lo, 0);
      chk("Hi.second_done_seen", seen, 1);
      @(posedge clk); #1;

      // Configuration corners on 0x20
      run_frame(1, 8'h20, "c1", lat, nstb, nstop, bits);
      chk("c1.latency", lat, 11);
      chk("c1.strobes", nstb, 11);
      chk("c1.bits", bits[10:0], 11'b00010000011);
      chk("c1.stop_hi", nstop, 2);
      run_frame(2, 8'h20, "c2", lat, nstb, nstop, bits);
      chk("c2.latency", lat, 48);
      chk("c2.stop_hi", nstop, 8);
      chk("c2.strobes", nstb, 12);

      // Reset during data bit 3 of 0x55
      in_valid[0] = 1'b1;
      in_data[0]  = 8'h55;
      wait_accept(0, "rst");
      in_valid[0] = 1'b0;
      nstb = 0;
      for (int k = 0; k < 100 && nstb < 6; k++) begin
         @(negedge clk);
         if (bit_strobe[0]) nstb++;
      end
      chk("rst.reached_bit3", nstb, 6);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst.tx_busy_ready", {tx_bit[0], tx_busy[0], in_ready[0]}, 3'b100);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("rst.ready_after_release", in_ready[0], 1);
      @(posedge clk); #1;
      run_frame(0, 8'h31, "rst31", lat, nstb, nstop, bits);
      chk("rst31.latency", lat, 44);
      chk("rst31.bits", bits[10:0], 11'b00011000111);

      // Stall: 0xFF offered mid-frame must be ignored
      in_valid[0] = 1'b1;
      in_data[0]  = 8'hAA;
      wait_accept(0, "stall");
      in_valid[0] = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      in_valid[0] = 1'b1;
      in_data[0]  = 8'hFF;
      @(negedge clk);
      chk("stall.ready_low", in_ready[0], 0);
      @(posedge clk); #1;
      in_valid[0] = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (frame_done[0]) begin
            seen = 1'b1;
            break;
         end
      end
      chk("stall.done_seen", seen, 1);
      repeat (6) @(negedge clk);
      chk("stall.idle_line", {tx_bit[0], tx_busy[0]}, 2'b10);

      // Randomized traffic on all three configurations
      for (int c = 0; c < 1500; c++) begin
         @(posedge clk); #1;
         rst_n = ($urandom_range(0, 499) != 0);
         for (int i = 0; i < int'(NI); i++) begin
            in_valid[i] = ($urandom_range(0, 3) != 0);
            in_data[i]  = 8'($urandom);
         end
      end
      @(posedge clk); #1;
      rst_n    = 1'b1;
      in_valid = '0;
      repeat (120) @(posedge clk);
      #1;
      mon_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
